// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions.
//   resp_t  : BRESP/RRESP encoding (OKAY, EXOKAY, SLVERR, DECERR).
//   state_t : command-master FSM states.
//   DATA_W  : AXI-Lite data width (fixed at 32).
package axil_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bus bundle.
//   Parameter ADDR_W : byte-address width.
//   modport master   : drives AW/W/AR payload+valid, BREADY, RREADY.
//   modport slave    : mirror image of master.
interface AxiLite #(
    parameter int ADDR_W = 8
);
    logic                        awvalid;
    logic                        awready;
    logic [ADDR_W-1:0]           awaddr;
    logic [2:0]                  awprot;

    logic                        wvalid;
    logic                        wready;
    logic [axil_pkg::DATA_W-1:0] wdata;
    logic [3:0]                  wstrb;

    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;

    logic                        arvalid;
    logic                        arready;
    logic [ADDR_W-1:0]           araddr;
    logic [2:0]                  arprot;

    logic                        rvalid;
    logic                        rready;
    logic [axil_pkg::DATA_W-1:0] rdata;
    logic [1:0]                  rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb,    input wready,
        input  bvalid, bresp,           output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp,    output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb,    output wready,
        output bvalid, bresp,           input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp,    input rready
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite command master.
// Accepts one read/write command at a time on a valid/ready command port,
// runs it on the AXI-Lite bus and returns the response (read data and the
// raw BRESP/RRESP) on a valid/ready response port.
//   clk, rst               : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake (ready only when idle)
//   cmd_write              : 1 = write, 0 = read
//   cmd_addr               : byte address, bits [1:0] forced to 0 on the bus
//   cmd_data/cmd_strb      : write data and byte strobes
//   rsp_valid/rsp_ready    : response handshake
//   rsp_data/rsp_resp      : read data (0 for writes), response code
//   bus                    : AXI-Lite master port
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [2:0] PROT   = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_resp,
    AxiLite.master            bus
);

    // Word-align the captured address.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [3:0]          strb_q, strb_d;
    logic                write_q, write_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    resp_t               rsp_resp_q, rsp_resp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            write_q    <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_resp_q <= OKAY;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            write_q    <= write_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        write_d    = write_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr & ADDR_MASK;
                    data_d  = cmd_data;
                    strb_d  = cmd_strb;
                    write_d = cmd_write;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; a valid that is already
                // low simply stays low, so the exit test covers either order
                // and the same-cycle case.
                awvalid_d = awvalid_q && !bus.awready;
                wvalid_d  = wvalid_q && !bus.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end
            end
            RD_REQ: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                end
            end
            WR_RESP, RD_RESP: begin
                // write_q selects which response channel is being waited on.
                if (write_q ? bus.bvalid : bus.rvalid) begin
                    rsp_data_d = write_q ? '0 : bus.rdata;
                    rsp_resp_d = resp_t'(write_q ? bus.bresp : bus.rresp);
                    state_d    = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so the port reads 0 while reset is held even though the
    // state register already sits in IDLE.
    assign cmd_ready = (state_q == IDLE) && !rst;

    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;

    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = addr_q;
    assign bus.awprot  = PROT;
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = data_q;
    assign bus.wstrb   = strb_q;
    assign bus.bready  = (state_q == WR_RESP);
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = addr_q;
    assign bus.arprot  = PROT;
    assign bus.rready  = (state_q == RD_RESP);

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the AXI-Lite byte-address width.
REQ-002 The block SHALL have parameter PROT, default 3'b000, meaning the constant driven on AWPROT and ARPROT.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 Ports SHALL be, in this order:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; bits [1:0] are ignored and driven as 0 on the bus.
- cmd_data  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_data  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP exactly as returned.
- bus  master modport  AxiLite #(ADDR_W)  AXI-Lite master port.

Function
REQ-005 The FSM SHALL have the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-006 cmd_ready SHALL be high only in IDLE; a handshake in IDLE SHALL capture addr, data, strb and write into registers.
REQ-007 On a write handshake, the FSM SHALL go to WR_REQ; AWVALID and WVALID SHALL assert on the next cycle with registered (non-combinational) values.
REQ-008 In WR_REQ, the block SHALL track AW and W acceptance independently; each valid SHALL drop the cycle after its own ready is sampled high; the FSM SHALL leave WR_REQ only once both channels are accepted, in either order or in the same cycle.
REQ-009 Once a valid is asserted, it SHALL NOT deassert, nor its payload change, before the matching ready.
REQ-010 In WR_RESP, BREADY SHALL be high; when BVALID is sampled high, BRESP SHALL be captured, rsp_data set to 0, and the FSM SHALL go to RSP.
REQ-011 On a read handshake, the FSM SHALL go to RD_REQ with ARVALID asserted; after ARREADY it SHALL go to RD_RESP.
REQ-012 In RD_RESP, RREADY SHALL be high; when RVALID is sampled high, RDATA and RRESP SHALL be captured and the FSM SHALL go to RSP.
REQ-013 BREADY and RREADY SHALL be low outside WR_RESP and RD_RESP respectively.
REQ-014 In RSP, rsp_valid SHALL be high with stable outputs until rsp_ready; the FSM SHALL then return to IDLE.
REQ-015 Only one transaction SHALL be outstanding at a time; no new command SHALL be accepted until the response is consumed.
REQ-016 With zero-wait slave and sink, latency SHALL be: cmd handshake, then 1 cycle of valid, then 1 cycle of response, then rsp_valid on cycle 3. A write SHALL take 4 cycles per command; a read SHALL take 4 cycles.
REQ-017 The block SHALL apply no response filtering; SLVERR and DECERR SHALL be passed through on rsp_resp, and read data SHALL still be forwarded.
REQ-018 BVALID or RVALID arriving while the block is not waiting SHALL be ignored, since the ready is low.

Reset
REQ-019 While rst is high, the FSM SHALL be in IDLE and every valid and ready output SHALL be 0, except cmd_ready, which is 0 during reset and 1 in the first cycle after release.
REQ-020 While rst is high, rsp_data, rsp_resp and the bus address, data and strobe registers SHALL be 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no completion response; the slave is reset by the same domain.

Structure
REQ-022 Shared package axil_pkg SHALL hold: the resp_t enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), the FSM state typedef, and the data width constant 32.
REQ-023 The block SHALL be a single module; no sub-module is required.

Verification
REQ-024 Bench SHALL use axil_cmd_master driving an AxilCsr with CTRL=5 and STAT=4. Write 0xCA55E77E, strb 0xF, addr 0x0, then read 0x0 -> rsp_resp 0 and rsp_data 0xCA55E77E.
REQ-025 Write 0xAAAAAAAA with strb 0x2 over prior 0x55555555 -> read returns 0x5555AA55.
REQ-026 Slave AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 3 cycles, exactly one response is produced, and data is written.
REQ-027 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stay stable and cmd_ready stays 0 throughout.
REQ-028 Slave returning DECERR on an out-of-range read -> rsp_resp 3.
REQ-029 rst pulsed while in WR_RESP -> all valids are 0 next cycle, no rsp_valid occurs, and the next command completes normally.
